dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle CPU's data bus: decodes the CPU's DM_ena/DM_w/addr/wdata requests, serves RAM with a configurable multi-cycle read latency, and drives the CPU `stall` input while a read is outstanding. It also maps a small timer register bank (count/compare/control) and drives `timer_int` into interrupt line int_i[0]. It replaces the zero-wait data memory instance in the top-level dataflow.

## Interface
- BASE_ADDR, 32'h1001_0000: first byte address of RAM.
- DEPTH_WORDS, 2048: RAM size in 32-bit words (power of two).
- WAIT_CYCLES, 1: stall cycles per RAM read (0 = no stall, combinational read).
- TIMER_BASE, 32'h1001_F000: timer bank base; must lie outside RAM.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- DM_ena  in  1  request valid.
- DM_w  in  1  1 = write, 0 = read.
- addr  in  32  byte address; addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data; valid in the cycle `stall` is low with a read request.
- stall  out  1  CPU freeze; CPU holds all request signals while high.
- timer_int  out  1  level interrupt = pending & ctrl.irq_en.
- bus_err  out  1  one-cycle pulse on an access to an unmapped address.

## Operation
- Decode: RAM if BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS, word index (addr-BASE_ADDR)>>2; TIMER if addr[31:4]==TIMER_BASE[31:4]; else unmapped.
- FSM states IDLE, WAIT, DONE (single instance, enum in package).
- IDLE: RAM read with WAIT_CYCLES>0 -> stall=1 combinationally, load wait counter = WAIT_CYCLES-1, go WAIT (or DONE if WAIT_CYCLES==1). WAIT: stall=1, decrement; at 0 go DONE. DONE: stall=0, rdata = registered RAM word, return to IDLE at edge.
- Writes (RAM or TIMER) and TIMER reads never stall; write commits at the edge where DM_ena&DM_w&!stall.
- Unmapped: write dropped, read returns 0, bus_err=1 that cycle, no stall.
- DM_ena low in IDLE: rdata=0, stall=0, nothing changes.
- Timer bank (offsets): 0x0 count RW; 0x4 compare RW, write clears pending; 0x8 ctrl: bit0 cnt_en RW, bit1 irq_en RW, bit2 pending (read; write 1 clears). Other bits read 0.
- count increments by 1 each cycle while cnt_en, wraps 0xFFFF_FFFF->0. When cnt_en and count==compare, pending sets next edge.
- Simultaneous events: CPU write to count beats increment; pending set beats write-1-clear in the same cycle; compare write clears pending unless the new compare equals count in that cycle's compare (set wins).

## Timing
- Reset values: stall 0, rdata 0, timer_int 0, bus_err 0, state IDLE, count 0, compare 0xFFFF_FFFF, ctrl 0. RAM contents not cleared.
- RAM read latency: WAIT_CYCLES+1 cycles from request to CPU advance; WAIT_CYCLES=0 -> same cycle.
- Reset asserted mid-read: FSM to IDLE, stall 0 next cycle; read abandoned.
- timer_int follows pending by 0 cycles (combinational AND of registers).
- Back-to-back reads: each incurs full latency; DONE->IDLE->new request, no bypass.

## Structure
- Package dmem_pkg: state enum, timer offsets (0x0/0x4/0x8), ctrl bit positions, default BASE_ADDR/TIMER_BASE constants.
- One sub-module dmem_timer: count/compare/ctrl registers, pending, timer_int; write/read port from the decoder.
- RAM array and FSM in dmem_responder.

## Test plan
- Reset, then write 0x1234_5678 to 0x1001_0010, read back -> stall high 1 cycle (WAIT_CYCLES=1), rdata 0x1234_5678 in DONE cycle.
- WAIT_CYCLES=3 read of 0x1001_0000 -> stall high exactly 3 cycles, then valid data; assert rst during 2nd stall cycle -> stall 0 next cycle, state IDLE.
- Write compare=5, ctrl=0x3 -> count reaches 5, pending and timer_int high the following cycle; write ctrl=0x7 -> pending cleared, timer_int 0.
- Write count=0xFFFF_FFFE with cnt_en -> reads 0xFFFF_FFFF then 0x0000_0000 (wrap).
- Read 0x2000_0000 -> rdata 0, bus_err pulse 1 cycle, no stall; write there -> RAM and timer unchanged.
- Same-cycle count==compare and ctrl write-1-clear -> pending remains 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its timer bank.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] TMR_COUNT   = 4'h0;
  localparam logic [3:0] TMR_COMPARE = 4'h4;
  localparam logic [3:0] TMR_CTRL    = 4'h8;

  localparam int CTRL_CNT_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PENDING = 2;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h1001_0000;
  localparam logic [31:0] DEF_TIMER_BASE = 32'h1001_F000;

endpackage

// File: rtl/dmem_timer.sv
// Free-running compare timer: count/compare/ctrl registers with a sticky pending flag.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_int
);

  logic [31:0] count, compare;
  logic        cnt_en, irq_en, pending;
  logic        wr_count, wr_cmp, wr_ctrl, hit;

  assign wr_count = we && (sel == TMR_COUNT[3:2]);
  assign wr_cmp   = we && (sel == TMR_COMPARE[3:2]);
  assign wr_ctrl  = we && (sel == TMR_CTRL[3:2]);
  assign hit      = cnt_en && (count == compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '1;
      cnt_en  <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_count)    count <= wdata;
      else if (cnt_en) count <= count + 32'd1;
      if (wr_cmp) compare <= wdata;
      if (wr_ctrl) begin
        cnt_en <= wdata[CTRL_CNT_EN];
        irq_en <= wdata[CTRL_IRQ_EN];
      end
      // A match in this cycle outranks any clear arriving in the same cycle.
      if (hit)                                           pending <= 1'b1;
      else if (wr_cmp || (wr_ctrl && wdata[CTRL_PENDING])) pending <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      TMR_COUNT[3:2]:   rdata = count;
      TMR_COMPARE[3:2]: rdata = compare;
      TMR_CTRL[3:2]: begin
        rdata[CTRL_CNT_EN]  = cnt_en;
        rdata[CTRL_IRQ_EN]  = irq_en;
        rdata[CTRL_PENDING] = pending;
      end
      default: rdata = '0;
    endcase
  end

  assign timer_int = pending & irq_en;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-bus responder: RAM with fixed read latency (stalling the CPU), timer bank,
// and bus-error flagging for unmapped addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] TIMER_BASE  = DEF_TIMER_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_ena,
  input  logic        DM_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        timer_int,
  output logic        bus_err
);

  localparam int          IW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam int          CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_M1 = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off, rd_q, tmr_rdata;
  logic [IW-1:0] idx;
  logic        ram_hit, tmr_hit, tmr_we;
  state_t      state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;

  assign off     = addr - BASE_ADDR;
  assign ram_hit = (addr >= BASE_ADDR) && (off < RAM_BYTES);
  assign idx     = off[IW+1:2];
  assign tmr_hit = (addr[31:4] == TIMER_BASE[31:4]);
  assign tmr_we  = DM_ena && DM_w && tmr_hit && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // RAM is not reset; the read word is latched at launch since the CPU cannot write while stalled.
  always_ff @(posedge clk) begin
    if (DM_ena && DM_w && !stall && ram_hit) mem[idx] <= wdata;
    if (state == S_IDLE && DM_ena && !DM_w && ram_hit) rd_q <= mem[idx];
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    stall   = 1'b0;
    rdata   = '0;
    bus_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (DM_ena) begin
          if (ram_hit) begin
            if (!DM_w) begin
              if (WAIT_CYCLES == 0) begin
                rdata = mem[idx];
              end else begin
                stall   = 1'b1;
                wcnt_n  = WAIT_M1;
                state_n = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
              end
            end
          end else if (tmr_hit) begin
            if (!DM_w) rdata = tmr_rdata;
          end else begin
            bus_err = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall  = 1'b1;
        wcnt_n = wcnt - 1'b1;
        if (wcnt_n == '0) state_n = S_DONE;
      end
      S_DONE: begin
        rdata   = rd_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  dmem_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .we        (tmr_we),
    .sel       (addr[3:2]),
    .wdata     (wdata),
    .rdata     (tmr_rdata),
    .timer_int (timer_int)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (1 and 3 wait cycles) checked every cycle
// against a transaction-level model, plus hand-computed literal expectations.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] TMR  = 32'h1001_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena [2];
  logic        w   [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        tint  [2];
  logic        berr  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // model state
  logic [31:0] mem [int];
  int          age  [2];
  logic [31:0] m_cnt [2];
  logic [31:0] m_cmp [2];
  bit          m_en [2], m_irq [2], m_pend [2];

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .DM_ena(ena[0]), .DM_w(w[0]), .addr(ad[0]), .wdata(wd[0]),
    .rdata(rdata[0]), .stall(stall[0]), .timer_int(tint[0]), .bus_err(berr[0])
  );

  dmem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .DM_ena(ena[1]), .DM_w(w[1]), .addr(ad[1]), .wdata(wd[1]),
    .rdata(rdata[1]), .stall(stall[1]), .timer_int(tint[1]), .bus_err(berr[1])
  );

  function automatic int wv(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] treg(input int i, input logic [1:0] s);
    case (s)
      2'd0:    return m_cnt[i];
      2'd1:    return m_cmp[i];
      2'd2:    return {29'd0, m_pend[i], m_irq[i], m_en[i]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_cycle(input int i);
    bit ram, tmr, rd, estall, chk_rd, set, wc_cnt, wc_cmp, wc_ctl;
    logic [31:0] off, erd;
    int key;
    off    = ad[i] - BASE;
    ram    = (ad[i] >= BASE) && (ad[i] < BASE + 32'h2000);
    tmr    = (ad[i][31:4] == TMR[31:4]);
    key    = i * 4096 + int'(off[12:2]);
    rd     = ena[i] && !w[i];
    estall = 0;
    chk_rd = 0;
    erd    = 0;
    if (!ena[i]) chk_rd = 1;
    else if (ram && rd) begin
      estall = age[i] < wv(i);
      if (!estall && mem.exists(key)) begin chk_rd = 1; erd = mem[key]; end
    end else if (tmr && rd) begin chk_rd = 1; erd = treg(i, ad[i][3:2]); end
    else if (!ram && !tmr && rd) chk_rd = 1;

    if (chk_en) begin
      check($sformatf("u%0d stall", i), 32'(stall[i]), 32'(estall));
      if (chk_rd && !estall) check($sformatf("u%0d rdata @%h", i, ad[i]), rdata[i], erd);
      check($sformatf("u%0d bus_err", i), 32'(berr[i]), 32'(ena[i] && !ram && !tmr));
      check($sformatf("u%0d timer_int", i), 32'(tint[i]), 32'(m_pend[i] && m_irq[i]));
    end

    if (rst) begin
      age[i] = 0; m_cnt[i] = 0; m_cmp[i] = '1; m_en[i] = 0; m_irq[i] = 0; m_pend[i] = 0;
    end else begin
      if (ram && rd) age[i] = (age[i] == wv(i)) ? 0 : age[i] + 1;
      else age[i] = 0;
      if (ena[i] && w[i] && !estall && ram) mem[key] = wd[i];
      wc_cnt = ena[i] && w[i] && tmr && ad[i][3:2] == 2'd0;
      wc_cmp = ena[i] && w[i] && tmr && ad[i][3:2] == 2'd1;
      wc_ctl = ena[i] && w[i] && tmr && ad[i][3:2] == 2'd2;
      set    = m_en[i] && (m_cnt[i] == m_cmp[i]);
      if (set) m_pend[i] = 1;
      else if (wc_cmp || (wc_ctl && wd[i][2])) m_pend[i] = 0;
      if (wc_cnt) m_cnt[i] = wd[i];
      else if (m_en[i]) m_cnt[i] = m_cnt[i] + 1;
      if (wc_cmp) m_cmp[i] = wd[i];
      if (wc_ctl) begin m_en[i] = wd[i][0]; m_irq[i] = wd[i][1]; end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_cycle(i);
    if (rst) chk_en = 1;
  end

  // Presents one request, holds it through any stall, returns the data and stall count.
  task automatic access(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls);
    ena[i] = 1; w[i] = wr; ad[i] = a; wd[i] = d;
    stalls = 0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!stall[i]) begin rd = rdata[i]; break; end
      stalls++;
    end
    if (stalls >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL u%0d timeout @%h: stall never dropped, required release within 20", i, a);
    end
    @(posedge clk); #1;
    ena[i] = 0; w[i] = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int st, k;
    for (int i = 0; i < 2; i++) begin ena[i] = 0; w[i] = 0; ad[i] = 0; wd[i] = 0; end
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    check("reset stall", 32'(stall[0]), 32'd0);
    check("reset rdata", rdata[0], 32'd0);
    check("reset timer_int", 32'(tint[0]), 32'd0);
    check("reset bus_err", 32'(berr[0]), 32'd0);
    step();

    access(0, 0, TMR + 32'h0, 0, rd, st); check("reset count", rd, 32'd0);
    access(0, 0, TMR + 32'h4, 0, rd, st); check("reset compare", rd, 32'hFFFF_FFFF);
    access(0, 0, TMR + 32'h8, 0, rd, st); check("reset ctrl", rd, 32'd0);

    access(0, 1, 32'h1001_0010, 32'h1234_5678, rd, st); check("write stalls", 32'(st), 32'd0);
    access(0, 0, 32'h1001_0010, 0, rd, st);
    check("w1 read stalls", 32'(st), 32'd1);
    check("w1 read data", rd, 32'h1234_5678);
    access(0, 1, 32'h1001_1FFC, 32'hA5A5_0001, rd, st);
    access(0, 0, 32'h1001_1FFC, 0, rd, st);
    check("last word data", rd, 32'hA5A5_0001);

    access(1, 1, 32'h1001_0000, 32'hCAFE_F00D, rd, st);
    access(1, 0, 32'h1001_0000, 0, rd, st);
    check("w3 read stalls", 32'(st), 32'd3);
    check("w3 read data", rd, 32'hCAFE_F00D);
    access(1, 0, 32'h1001_0000, 0, rd, st);
    check("w3 back-to-back stalls", 32'(st), 32'd3);

    // reset lands in the second stall cycle of a read
    ena[1] = 1; w[1] = 0; ad[1] = 32'h1001_0000;
    @(negedge clk); check("w3 first stall", 32'(stall[1]), 32'd1);
    step(); rst = 1;
    step(); rst = 0; ena[1] = 0;
    @(negedge clk); check("stall after reset", 32'(stall[1]), 32'd0);
    step();
    access(1, 0, 32'h1001_0000, 0, rd, st);
    check("post-reset stalls", 32'(st), 32'd3);
    check("post-reset ram kept", rd, 32'hCAFE_F00D);

    // timer match and interrupt
    access(0, 1, TMR + 32'h4, 32'd5, rd, st);
    access(0, 1, TMR + 32'h8, 32'h3, rd, st);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tint[0]) break;
    end
    check("timer_int latency", 32'(k), 32'd7);
    step();
    access(0, 1, TMR + 32'h8, 32'h7, rd, st);
    @(negedge clk); check("timer_int cleared", 32'(tint[0]), 32'd0);
    step();

    access(0, 1, TMR + 32'h0, 32'hFFFF_FFFE, rd, st);
    step();
    access(0, 0, TMR + 32'h0, 0, rd, st); check("count pre-wrap", rd, 32'hFFFF_FFFF);
    access(0, 0, TMR + 32'h0, 0, rd, st); check("count wrap", rd, 32'h0000_0000);

    // unmapped accesses
    ena[0] = 1; w[0] = 0; ad[0] = 32'h2000_0000;
    @(negedge clk);
    check("unmapped bus_err", 32'(berr[0]), 32'd1);
    check("unmapped rdata", rdata[0], 32'd0);
    check("unmapped stall", 32'(stall[0]), 32'd0);
    step(); ena[0] = 0;
    @(negedge clk); check("bus_err one cycle", 32'(berr[0]), 32'd0);
    step();
    access(0, 0, 32'h1001_2000, 0, rd, st); check("past-end rdata", rd, 32'd0);
    access(0, 1, 32'h2000_0000, 32'hDEAD_BEEF, rd, st);
    access(0, 0, 32'h1001_0010, 0, rd, st); check("ram untouched", rd, 32'h1234_5678);
    access(0, 0, TMR + 32'h4, 0, rd, st); check("compare untouched", rd, 32'd5);
    access(0, 0, TMR + 32'hC, 0, rd, st); check("reserved offset", rd, 32'd0);

    // match and write-1-clear in the same cycle: set wins
    access(0, 1, TMR + 32'h8, 32'h4, rd, st);
    access(0, 1, TMR + 32'h0, 32'd100, rd, st);
    access(0, 1, TMR + 32'h4, 32'd102, rd, st);
    access(0, 1, TMR + 32'h8, 32'h3, rd, st);
    step(); step();
    access(0, 1, TMR + 32'h8, 32'h7, rd, st);
    access(0, 0, TMR + 32'h8, 0, rd, st); check("pending survives w1c", rd, 32'h7);
    @(negedge clk); check("timer_int held", 32'(tint[0]), 32'd1);
    step();
    access(0, 1, TMR + 32'h8, 32'h4, rd, st);
    access(0, 0, TMR + 32'h8, 0, rd, st); check("pending cleared", rd, 32'h0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
